// File: rtl/quan_ctrl_pkg.sv
// Shared state encoding and default timing/credit constants for the
// quantization issue scheduler and its valid delay line.
package quan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WAIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int DEF_LAT_ZERO     = 21;
    localparam int DEF_LAT_LEAKY    = 32;
    localparam int DEF_CREDIT_DEPTH = 64;

endpackage

// File: rtl/quan_valid_delay.sv
// Valid delay line for the quantization pipeline: a cleared shift register with a tap
// select latched on layer start. Macro QUAN_LEAKY_EN enables the second (leaky) tap.
module quan_valid_delay
    import quan_ctrl_pkg::*;
#(
    parameter int LAT_ZERO  = DEF_LAT_ZERO,
    parameter int LAT_LEAKY = DEF_LAT_LEAKY
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    input  logic load,
    input  logic bypass,
    output logic dout,
    output logic dout_next
);

`ifdef QUAN_LEAKY_EN
    localparam int DEPTH = LAT_LEAKY;

    logic bypass_q;

    always_ff @(posedge clk) begin
        if (rst)
            bypass_q <= 1'b1;
        else if (load)
            bypass_q <= bypass;
    end
`else
    localparam int DEPTH = LAT_ZERO;

    logic unused_cfg;
    assign unused_cfg = load ^ bypass;
`endif

    logic [DEPTH-1:0] sr;

    // NOTE: the delay line is cleared on reset so no stale valid escapes after a mid-layer reset.
    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else
            sr <= {sr[DEPTH-2:0], din};
    end

`ifdef QUAN_LEAKY_EN
    assign dout      = bypass_q ? sr[LAT_ZERO-1] : sr[LAT_LEAKY-1];
    assign dout_next = bypass_q ? sr[LAT_ZERO-2] : sr[LAT_LEAKY-2];
`else
    assign dout      = sr[DEPTH-1];
    assign dout_next = sr[DEPTH-2];
`endif

endmodule

// File: rtl/conv_quan_sched.sv
// Issue scheduler for the convolution quantization pipeline: row/group/column read
// sequencing, parameter RAM addressing, credit flow control and aligned output valid.
module conv_quan_sched
    import quan_ctrl_pkg::*;
#(
    parameter int WIDTH_FEATURE_SIZE    = 12,
    parameter int WIDTH_CHANNEL_NUM_REG = 10,
    parameter int WIDTH_BIAS_RAM_ADDRA  = 9,
    parameter int CREDIT_DEPTH          = DEF_CREDIT_DEPTH,
    parameter int LAT_ZERO              = DEF_LAT_ZERO,
    parameter int LAT_LEAKY             = DEF_LAT_LEAKY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             Start,
    input  logic                             Leaky_REG,
    input  logic [WIDTH_FEATURE_SIZE-1:0]    Row_Num_Out_REG,
    input  logic [WIDTH_CHANNEL_NUM_REG-1:0] Channel_Out_Num_REG,
    input  logic                             Fifo_Ready,
    input  logic                             M_Pop,
    output logic                             EN_Rd_Fifo,
    output logic [WIDTH_BIAS_RAM_ADDRA-1:0]  bias_addrb,
    output logic                             M_Valid,
    output logic                             Busy,
    output logic                             Done
);

    localparam int CREDIT_W = $clog2(CREDIT_DEPTH + 1);
    localparam int INFL_W   = $clog2(CREDIT_DEPTH + LAT_LEAKY + 1);
    localparam logic [CREDIT_W-1:0] CREDIT_FULL = CREDIT_W'(CREDIT_DEPTH);

    state_t                           state;
    logic [WIDTH_FEATURE_SIZE-1:0]    row_num;
    logic [WIDTH_FEATURE_SIZE-1:0]    r;
    logic [WIDTH_FEATURE_SIZE-1:0]    c;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] ch_num;
    logic [WIDTH_CHANNEL_NUM_REG-1:0] g;
    logic [CREDIT_W-1:0]              credit;
    logic [INFL_W-1:0]                inflight;
    logic [INFL_W-1:0]                inflight_next;
    logic                             start_ok;
    logic                             valid_next;
    logic                             row_end;
    logic                             grp_end;
    logic                             last_row;

    assign start_ok   = (state == ST_IDLE) && Start;
    assign EN_Rd_Fifo = (state == ST_RUN) && (credit != '0);
    assign row_end    = (c == row_num - 1'b1);
    assign grp_end    = (g == ch_num - 1'b1);
    assign last_row   = (r == row_num - 1'b1);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inflight_next = inflight;
        if (EN_Rd_Fifo && !M_Valid)
            inflight_next = inflight + 1'b1;
        else if (!EN_Rd_Fifo && M_Valid)
            inflight_next = inflight - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit   <= CREDIT_FULL;
            inflight <= '0;
        end else begin
            inflight <= inflight_next;
            if (EN_Rd_Fifo && !M_Pop)
                credit <= credit - 1'b1;
            else if (!EN_Rd_Fifo && M_Pop && credit != CREDIT_FULL)
                credit <= credit + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            row_num    <= '0;
            ch_num     <= '0;
            r          <= '0;
            g          <= '0;
            c          <= '0;
            bias_addrb <= '0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            Done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (Start) begin
                        row_num <= Row_Num_Out_REG;
                        ch_num  <= Channel_Out_Num_REG;
                        r       <= '0;
                        g       <= '0;
                        c       <= '0;
                        Busy    <= 1'b1;
                        state   <= (Row_Num_Out_REG == '0 || Channel_Out_Num_REG == '0)
                                   ? ST_DONE : ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    bias_addrb <= WIDTH_BIAS_RAM_ADDRA'(g);
                    state      <= Fifo_Ready ? ST_RUN : ST_WAIT;
                end
                ST_WAIT: begin
                    if (Fifo_Ready)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (EN_Rd_Fifo) begin
                        if (row_end) begin
                            c <= '0;
                            if (grp_end) begin
                                g <= '0;
                                if (last_row) begin
                                    state <= ST_DRAIN;
                                end else begin
                                    r     <= r + 1'b1;
                                    state <= ST_SETUP;
                                end
                            end else begin
                                g     <= g + 1'b1;
                                state <= ST_SETUP;
                            end
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave one cycle early when the final beat is next, so Done trails it by one.
                    if (inflight_next == '0 || (inflight_next == INFL_W'(1) && valid_next))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    quan_valid_delay #(
        .LAT_ZERO  (LAT_ZERO),
        .LAT_LEAKY (LAT_LEAKY)
    ) u_valid_delay (
        .clk       (clk),
        .rst       (rst),
        .din       (EN_Rd_Fifo),
        .load      (start_ok),
        .bypass    (Leaky_REG),
        .dout      (M_Valid),
        .dout_next (valid_next)
    );

endmodule
